// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit multiplexed 7-segment scan controller.
// Each digit gets a dead-time window with all anodes off, then an ON window.
// New display data is double-buffered through a shadow register. It becomes
// visible only at the frame wrap (digit 3 -> digit 0), so a frame never shows
// a mix of old and new digits. Optional leading-zero blanking is supported.
// All outputs are registered from the current FSM state. Every output therefore
// trails the internal state by one cycle. The window lengths and the frame
// period are unchanged by this lag.
module seg_scan_ctrl #(
    parameter int ON_CYC   = 50000,
    parameter int DEAD_CYC = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        lzb,
    output logic        ack,
    output logic [3:0]  bin,
    output logic [1:0]  select,
    output logic [3:0]  an
);

    localparam int MAXC = (ON_CYC > DEAD_CYC) ? ON_CYC : DEAD_CYC;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] ON_LAST   = CW'(ON_CYC - 1);
    localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYC - 1);

    typedef enum logic {DEAD, ON} state_t;

    state_t          state, state_nx;
    logic [1:0]      dig, dig_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic            wrap;

    logic [15:0]     shadow;
    logic [3:0][3:0] disp;
    logic            pending;
    logic            commit;

    logic [3:0]      hi_zero;
    logic [3:0]      lit;
    logic [3:0]      an_nx;

    // Scan FSM state, digit index and cycle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= DEAD;
            dig   <= 2'd0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            dig   <= dig_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state logic: DEAD_CYC cycles dark, then ON_CYC cycles lit, then the next digit
    always_comb begin
        state_nx = state;
        dig_nx   = dig;
        cnt_nx   = cnt + CW'(1);
        wrap     = 1'b0;
        case (state)
            DEAD: begin
                if (cnt == DEAD_LAST) begin
                    state_nx = ON;
                    cnt_nx   = '0;
                end
            end
            ON: begin
                if (cnt == ON_LAST) begin
                    state_nx = DEAD;
                    cnt_nx   = '0;
                    dig_nx   = dig + 2'd1;
                    wrap     = (dig == 2'd3);
                end
            end
            default: begin
                state_nx = DEAD;
                cnt_nx   = '0;
            end
        endcase
    end

    assign commit = wrap & pending;

    // Double buffer: load captures into shadow, and the frame wrap publishes it.
    // A load in the same cycle as a commit keeps pending set. The commit takes the
    // old shadow, and the newly captured value waits for the next wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow  <= 16'h0000;
            disp    <= '0;
            pending <= 1'b0;
        end else begin
            if (commit) begin
                disp    <= shadow;
                pending <= 1'b0;
            end
            if (load) begin
                shadow  <= value;
                pending <= 1'b1;
            end
        end
    end

    // Per-digit anode decode with leading-zero blanking. Digit k is blanked when
    // it and every more significant nibble are zero. Digit 0 always lights.
    for (genvar k = 0; k < 4; k++) begin : g_dig
        assign hi_zero[k] = (disp[3:k] == '0);
        assign lit[k]     = (state == ON) && (dig == 2'(k)) &&
                            !(lzb && (k != 0) && hi_zero[k]);
    end

    assign an_nx = ~lit;

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an     <= 4'b1111;
            select <= 2'd0;
            bin    <= 4'h0;
            ack    <= 1'b0;
        end else begin
            an     <= an_nx;
            select <= dig;
            bin    <= disp[dig];
            ack    <= commit;
        end
    end

endmodule
